interrupt_controller: RTL

Prioritised, maskable interrupt controller that sequences the RISC processor's single INT input. It collects up to NUM_SRC edge-triggered peripheral requests and latches them as pending. It presents the highest-priority unmasked request to the processor with a 16-bit vector address. It then tracks the request through the ack/service/end-of-interrupt handshake. Control and status registers are accessed through a small synchronous register port.

---
 rtl/intc_pkg.sv | 17 +
 rtl/interrupt_controller_prio_encoder.sv | 24 ++
 rtl/interrupt_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_ISR  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int ID_W = 4;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Lowest-index-wins priority encoder over the unmasked pending set.
module prio_encoder
    import intc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req_i,
    output logic [ID_W-1:0] id_o,
    output logic            valid_o
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, maskable, non-nested interrupt controller driving a
// single INT line with a vector address and ack/eoi handshake.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_SRC  = 8,
    parameter logic [15:0] VEC_BASE = 16'h0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               INT,
    output logic [15:0]        int_vec,
    input  logic               int_ack,
    input  logic               eoi
);

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] rise, cur_oh, req_vec;
    logic               en_q, en_d;
    logic               int_q;
    logic [15:0]        vec_q;
    logic [ID_W-1:0]    cur_id_q, win_id;
    logic               win_vld;
    state_e             state_q;
    logic               wr_mask, wr_pend, wr_ctrl;
    logic               ack_go, eoi_go;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign wr_mask = cfg_we && (cfg_addr == ADDR_MASK);
    assign wr_pend = cfg_we && (cfg_addr == ADDR_PEND);
    assign wr_ctrl = cfg_we && (cfg_addr == ADDR_CTRL);

    assign ack_go  = (state_q == REQ) && int_ack;
    assign eoi_go  = (state_q == SERVICE) && eoi;

    assign rise    = irq_src & ~irq_prev_q;
    assign req_vec = pend_q & ~mask_q;

    assign INT     = int_q;
    assign int_vec = vec_q;

    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_oh[i] = (cur_id_q == ID_W'(i));
        end
    end

    prio_encoder #(
        .N       (NUM_SRC)
    ) u_prio (
        .req_i   (req_vec),
        .id_o    (win_id),
        .valid_o (win_vld)
    );

    // New edges are OR-ed in last so a set beats any clear this cycle.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) pend_d &= ~cfg_wdata[NUM_SRC-1:0];
        if (ack_go)  pend_d &= ~cur_oh;
        pend_d |= rise;

        isr_d = isr_q;
        if (ack_go) isr_d |= cur_oh;
        if (eoi_go) isr_d &= ~cur_oh;

        mask_d = wr_mask ? cfg_wdata[NUM_SRC-1:0] : mask_q;
        en_d   = wr_ctrl ? cfg_wdata[0] : en_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            isr_q      <= '0;
            mask_q     <= '1;
            irq_prev_q <= '0;
            en_q       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            isr_q      <= isr_d;
            mask_q     <= mask_d;
            irq_prev_q <= irq_src;
            en_q       <= en_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            int_q    <= 1'b0;
            vec_q    <= '0;
            cur_id_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_q && win_vld) begin
                        cur_id_q <= win_id;
                        vec_q    <= VEC_BASE + {10'd0, win_id, 2'b00};
                        int_q    <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_q   <= 1'b0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            ADDR_MASK: cfg_rdata = 16'(mask_q);
            ADDR_PEND: cfg_rdata = 16'(pend_q);
            ADDR_ISR:  cfg_rdata = 16'(isr_q);
            ADDR_CTRL: cfg_rdata = {6'd0, state_q, cur_id_q, 3'd0, en_q};
            default:   cfg_rdata = '0;
        endcase
    end

endmodule
